// File: rtl/axi_rd_slave_mem.sv
// AXI read slave serving one burst at a time from internal memory; define AXI_RD_SLAVE_SLVERR_EN for SLVERR responses.
// Latency: first R beat one cycle after the AR handshake, then one beat per cycle with no bubbles.
// Backpressure: an R beat holds stable while RREADY is low; ARREADY stays low for the whole burst.
module axi_rd_slave_mem #(
    parameter int AWID_WIDTH   = 4,
    parameter int AWADDR_WIDTH = 32,
    parameter int WDATA_WIDTH  = 64,
    parameter int MEM_DEPTH    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AWID_WIDTH-1:0]   ARID,
    input  logic [AWADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [3:0]              ARREGION,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [AWID_WIDTH-1:0]   RID,
    output logic [WDATA_WIDTH-1:0]  RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    mem_we,
    input  logic [AWADDR_WIDTH-1:0] mem_waddr,
    input  logic [WDATA_WIDTH-1:0]  mem_wdata
);
    localparam int OFF  = $clog2(WDATA_WIDTH / 8);
    localparam int IDXW = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state;

    logic [WDATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [AWADDR_WIDTH-1:0] addr_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;

    logic [AWADDR_WIDTH-1:0] la_addr, la_word, nxt_addr, waddr_word;
    logic [2:0]              ar_size_eff, la_size;
    logic [1:0]              la_burst;
    logic [IDXW-1:0]         la_idx;
    logic                    la_err;
    logic                    ar_hs, r_hs;
    logic                    unused_sig;

`ifdef AXI_RD_SLAVE_SLVERR_EN
    logic ar_berr, berr_q;
    assign ar_berr = (ARBURST == 2'b11) || (ARSIZE > 3'(OFF));
`endif

    assign ARREADY = (state == IDLE) && !rst;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RVALID && RREADY;

    assign waddr_word = mem_waddr >> OFF;
    assign unused_sig = ^{ARREGION, la_word, waddr_word};

    // The launch address comes straight from AR for the first beat, else from the running pointer.
    always_comb begin
        ar_size_eff = (ARSIZE > 3'(OFF)) ? 3'(OFF) : ARSIZE;
        la_addr     = (state == IDLE) ? ARADDR      : addr_q;
        la_size     = (state == IDLE) ? ar_size_eff : size_q;
        la_burst    = (state == IDLE) ? ARBURST     : burst_q;
        la_word     = la_addr >> OFF;
        la_idx      = la_word[IDXW-1:0];
        nxt_addr    = (la_burst == 2'b00) ? la_addr
                                          : la_addr + (AWADDR_WIDTH'(1) << la_size);
`ifdef AXI_RD_SLAVE_SLVERR_EN
        la_err      = (la_word >= AWADDR_WIDTH'(MEM_DEPTH))
                      || ((state == IDLE) ? ar_berr : berr_q);
`else
        la_err      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr_word[IDXW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= 2'b00;
            beat_cnt <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            len_q    <= '0;
`ifdef AXI_RD_SLAVE_SLVERR_EN
            berr_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state    <= BURST;
                        RID      <= ARID;
                        len_q    <= ARLEN;
                        size_q   <= ar_size_eff;
                        burst_q  <= ARBURST;
                        beat_cnt <= '0;
                        RLAST    <= (ARLEN == 8'd0);
                        RVALID   <= 1'b1;
                        RDATA    <= la_err ? '0 : mem[la_idx];
                        RRESP    <= la_err ? 2'b10 : 2'b00;
                        addr_q   <= nxt_addr;
`ifdef AXI_RD_SLAVE_SLVERR_EN
                        berr_q   <= ar_berr;
`endif
                    end
                end
                BURST: begin
                    if (r_hs) begin
                        if (RLAST) begin
                            state  <= IDLE;
                            RVALID <= 1'b0;
                            RLAST  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            RLAST    <= ((beat_cnt + 8'd1) == len_q);
                            RDATA    <= la_err ? '0 : mem[la_idx];
                            RRESP    <= la_err ? 2'b10 : 2'b00;
                            addr_q   <= nxt_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Bench for axi_rd_slave_mem: directed burst table, hand sequences for reset and same-cycle writes,
// then random bursts scored against a per-beat address model.
module tb_axi_rd_slave_mem;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [63:0] mem_wdata;

    always #5 clk = ~clk;

    axi_rd_slave_mem dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    logic [63:0] model_mem [DEPTH];
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          rmode;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
        logic [1:0]  exp_lresp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: beat i reads byte address base + i*bytes (FIXED: base), word = addr/bytes_per_word mod depth.
    function automatic void model_beat(input logic [31:0] a, input int i, input logic [2:0] sz,
                                       input logic [1:0] bu, output logic [63:0] d,
                                       output logic [1:0] r);
        int unsigned step;
        logic [31:0] ba;
        logic [31:0] w;
        step = (sz > 3'd3) ? 8 : (1 << sz);
        ba   = (bu == 2'b00) ? a : a + 32'(i) * step;
        w    = ba / 8;
        d    = model_mem[w % DEPTH];
        r    = 2'b00;
`ifdef AXI_RD_SLAVE_SLVERR_EN
        if (bu == 2'b11 || sz > 3'd3 || w >= DEPTH) begin
            d = '0;
            r = 2'b10;
        end
`endif
    endfunction

    task automatic preload(input int idx, input logic [63:0] d);
        mem_we    = 1'b1;
        mem_waddr = 32'(idx) << 3;
        mem_wdata = d;
        @(posedge clk); #1;
        mem_we    = 1'b0;
        model_mem[idx % DEPTH] = d;
    endtask

    // Entered and left at #1 after a rising edge. rmode: 0 always ready, 1 ready 1,0,0 pattern, 2 random.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int rmode,
                             output logic [63:0] fd, output logic [63:0] ld, output logic [1:0] lr);
        logic [63:0] ed, hd;
        logic [1:0]  er, hr;
        logic        hl, held, rr;
        logic [3:0]  hid;
        int          k, cyc;
        fd = '0; ld = '0; lr = '0;
        hd = '0; hr = '0; hl = 1'b0; hid = '0;
        chk("arready_idle", 64'(ARREADY), 64'd1);
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARREGION = 4'($urandom_range(0, 15));
        RREADY = 1'b0;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        k = 0; cyc = 0; held = 1'b0;
        while (k <= int'(len) && cyc < 500) begin
            chk("rvalid_in_burst", 64'(RVALID), 64'd1);
            chk("arready_busy", 64'(ARREADY), 64'd0);
            if (held) begin
                chk("hold_rdata", RDATA, hd);
                chk("hold_rresp", 64'(RRESP), 64'(hr));
                chk("hold_rlast", 64'(RLAST), 64'(hl));
                chk("hold_rid", 64'(RID), 64'(hid));
            end
            case (rmode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 3 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            RREADY = rr;
            if (RVALID && rr) begin
                model_beat(addr, k, size, burst, ed, er);
                chk("beat_rdata", RDATA, ed);
                chk("beat_rresp", 64'(RRESP), 64'(er));
                chk("beat_rid", 64'(RID), 64'(id));
                chk("beat_rlast", 64'(RLAST), 64'(k == int'(len)));
                if (k == 0) fd = RDATA;
                ld = RDATA; lr = RRESP;
                k++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hd = RDATA; hr = RRESP; hl = RLAST; hid = RID;
            end
            @(posedge clk); #1;
            cyc++;
        end
        RREADY = 1'b0;
        if (k <= int'(len)) chk("burst_timeout_beats", 64'(k), 64'(int'(len) + 1));
        chk("rvalid_after_last", 64'(RVALID), 64'd0);
        chk("arready_after_last", 64'(ARREADY), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fd, ld;
        logic [1:0]  lr;
        rst = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARREGION = '0; ARVALID = 1'b0; RREADY = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_rid", 64'(RID), 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        rst = 1'b0;
        #1;
        chk("arready_after_rst", 64'(ARREADY), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) preload(i, 64'hA0 + 64'(i));

        vecs[0] = '{4'd5, 32'h0,   8'd3, 3'd3, 2'b01, 0, 64'hA0, 64'hA3, 2'b00};
        vecs[1] = '{4'd5, 32'h0,   8'd3, 3'd3, 2'b01, 1, 64'hA0, 64'hA3, 2'b00};
        vecs[2] = '{4'd2, 32'h10,  8'd2, 3'd3, 2'b00, 0, 64'hA2, 64'hA2, 2'b00};
        vecs[3] = '{4'd3, 32'h18,  8'd0, 3'd3, 2'b01, 0, 64'hA3, 64'hA3, 2'b00};
        vecs[4] = '{4'd7, 32'h20,  8'd0, 3'd3, 2'b01, 0, 64'hA4, 64'hA4, 2'b00};
        vecs[5] = '{4'd1, 32'h0,   8'd3, 3'd2, 2'b01, 1, 64'hA0, 64'hA1, 2'b00};
        vecs[6] = '{4'd6, 32'h8,   8'd1, 3'd3, 2'b10, 0, 64'hA1, 64'hA2, 2'b00};
`ifdef AXI_RD_SLAVE_SLVERR_EN
        vecs[7] = '{4'd4, 32'h7F8, 8'd1, 3'd3, 2'b01, 0, 64'h19F, 64'h0, 2'b10};
        vecs[8] = '{4'd8, 32'h0,   8'd1, 3'd4, 2'b01, 0, 64'h0,   64'h0, 2'b10};
        vecs[9] = '{4'd9, 32'h0,   8'd1, 3'd3, 2'b11, 0, 64'h0,   64'h0, 2'b10};
`else
        vecs[7] = '{4'd4, 32'h7F8, 8'd1, 3'd3, 2'b01, 0, 64'h19F, 64'hA0, 2'b00};
        vecs[8] = '{4'd8, 32'h0,   8'd1, 3'd4, 2'b01, 0, 64'hA0,  64'hA1, 2'b00};
        vecs[9] = '{4'd9, 32'h0,   8'd1, 3'd3, 2'b11, 0, 64'hA0,  64'hA1, 2'b00};
`endif
        // Entries 3 and 4 run back to back: the second AR goes out the cycle after the single beat.
        for (int v = 0; v < 10; v++) begin
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                      vecs[v].rmode, fd, ld, lr);
            chk("vec_first_rdata", fd, vecs[v].exp_first);
            chk("vec_last_rdata", ld, vecs[v].exp_last);
            chk("vec_last_rresp", 64'(lr), 64'(vecs[v].exp_lresp));
        end

        // A preload write to the word being launched must not be visible in that beat.
        ARVALID = 1'b1; ARID = 4'd10; ARADDR = 32'h48; ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01;
        mem_we = 1'b1; mem_waddr = 32'h48; mem_wdata = 64'hDEAD_BEEF_0000_0009;
        @(posedge clk); #1;
        ARVALID = 1'b0; mem_we = 1'b0;
        chk("same_cycle_write_rvalid", 64'(RVALID), 64'd1);
        chk("same_cycle_write_old_data", RDATA, 64'hA9);
        model_mem[9] = 64'hDEAD_BEEF_0000_0009;
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0;
        chk("same_cycle_write_done", 64'(RVALID), 64'd0);
        run_burst(4'd10, 32'h48, 8'd0, 3'd3, 2'b01, 0, fd, ld, lr);
        chk("write_visible_next_burst", fd, 64'hDEAD_BEEF_0000_0009);

        // Reset pulse while the second beat of a 4-beat burst is presented.
        ARVALID = 1'b1; ARID = 4'd9; ARADDR = 32'h0; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01;
        RREADY = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        chk("rstmid_beat1", RDATA, 64'hA0);
        @(posedge clk); #1;
        chk("rstmid_beat2", RDATA, 64'hA1);
        rst = 1'b1;
        #1;
        chk("rstmid_arready_low", 64'(ARREADY), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        RREADY = 1'b0;
        chk("rstmid_rvalid", 64'(RVALID), 64'd0);
        chk("rstmid_rlast", 64'(RLAST), 64'd0);
        chk("rstmid_rdata", RDATA, 64'd0);
        #1;
        chk("rstmid_arready_high", 64'(ARREADY), 64'd1);
        @(posedge clk); #1;
        run_burst(4'd12, 32'h8, 8'd2, 3'd3, 2'b01, 2, fd, ld, lr);
        chk("rstmid_new_first", fd, 64'hA1);
        chk("rstmid_new_last", ld, 64'hA3);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                preload(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            run_burst(4'($urandom_range(0, 15)), 32'($urandom_range(0, 32'h0A00)),
                      8'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
                      2'($urandom_range(0, 3)), 2, fd, ld, lr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_rd_slave_mem.md
AXI_RD_SLAVE_MEM -- requirements
Module: axi_rd_slave_mem

Interface
REQ-001 Parameter AWID_WIDTH, default 4, width of ARID/RID.
REQ-002 Parameter AWADDR_WIDTH, default 32, width of ARADDR and mem_waddr.
REQ-003 Parameter WDATA_WIDTH, default 64, width of RDATA/mem_wdata; power of two, 8..1024.
REQ-004 Parameter MEM_DEPTH, default 256, number of WDATA_WIDTH words in internal memory; power of two.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ARID  in  AWID_WIDTH  read request ID.
REQ-008 ARADDR  in  AWADDR_WIDTH  byte start address.
REQ-009 ARLEN  in  8  beats minus one.
REQ-010 ARSIZE  in  3  log2 bytes per beat.
REQ-011 ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 ARREGION  in  4  ignored.
REQ-013 ARVALID  in  1 / ARREADY  out  1  AR handshake.
REQ-014 RID  out  AWID_WIDTH / RDATA  out  WDATA_WIDTH / RRESP  out  2 / RLAST  out  1  read beat payload.
REQ-015 RVALID  out  1 / RREADY  in  1  R handshake.
REQ-016 mem_we  in  1 / mem_waddr  in  AWADDR_WIDTH / mem_wdata  in  WDATA_WIDTH  bench preload port, byte address, full-word write.

Function
REQ-017 The block SHALL be an AXI read slave feeding the R channel from internal memory, one burst outstanding at a time.
REQ-018 FSM states SHALL be IDLE and BURST; IDLE->BURST on ARVALID&&ARREADY; BURST->IDLE on RVALID&&RREADY&&RLAST.
REQ-019 ARREADY SHALL be 1 in IDLE and 0 in BURST; ARID/ARADDR/ARLEN/ARSIZE/ARBURST SHALL be captured on handshake.
REQ-020 First RVALID SHALL assert the cycle after the AR handshake (latency 1).
REQ-021 RVALID, RID, RDATA, RRESP, RLAST SHALL hold stable while RVALID&&!RREADY.
REQ-022 On each R handshake a next beat, if any, SHALL present in the following cycle with no bubble.
REQ-023 Word index SHALL be byte address >> log2(WDATA_WIDTH/8), taken modulo MEM_DEPTH; RDATA is the full word.
REQ-024 INCR and WRAP (WRAP treated as INCR) SHALL advance the byte address by 2^ARSIZE per beat; FIXED SHALL keep it constant.
REQ-025 Beat counter SHALL be 8 bits; RLAST SHALL be 1 exactly on beat ARLEN (ARLEN=0 -> first beat).
REQ-026 RID SHALL equal the captured ARID on every beat; RRESP SHALL be 2'b00 unless REQ-031 applies.
REQ-027 RDATA SHALL be read from memory when a beat is launched; a mem_we to the same word in that cycle SHALL NOT be visible (old data).
REQ-028 mem_we SHALL write mem_wdata to word index of mem_waddr at the clock edge, in any state.

Reset
REQ-029 While rst=1: state IDLE, ARREADY 0, RVALID 0, RLAST 0, RID 0, RDATA 0, RRESP 0, beat counter 0; memory contents unchanged.
REQ-030 Reset during BURST SHALL abort the burst; ARREADY SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-031 With macro AXI_RD_SLAVE_SLVERR_EN defined: a beat whose word index >= MEM_DEPTH, or any beat of a burst with ARBURST=11 or 2^ARSIZE > WDATA_WIDTH/8, SHALL return RRESP=2'b10 and RDATA=0, burst length unchanged.
REQ-032 Without AXI_RD_SLAVE_SLVERR_EN: addresses wrap modulo MEM_DEPTH, ARBURST=11 behaves as INCR, oversize ARSIZE is clamped to WDATA_WIDTH/8 bytes, and RRESP is always 2'b00.

Verification
REQ-033 Preload words 0..3 with 0xA0..0xA3; AR INCR ARADDR=0 ARLEN=3 ARSIZE=3 ARID=5, RREADY=1 -> RVALID from T+1 for 4 consecutive cycles, RDATA A0..A3, RID=5, RLAST on 4th beat only.
REQ-034 Same burst with RREADY toggling 1,0,0,1,... -> each beat held stable while RREADY=0, no beat lost or duplicated, ARREADY=0 until last handshake.
REQ-035 FIXED ARADDR=0x10 ARLEN=2 -> three beats all equal to word 2, RLAST on 3rd.
REQ-036 ARLEN=0 -> single beat with RLAST=1; ARREADY=1 the cycle after its handshake, back-to-back AR accepted.
REQ-037 rst=1 for one cycle during beat 2 of a 4-beat burst -> RVALID=0 next cycle, ARREADY=1 after rst drops, new burst returns correct data.
REQ-038 With AXI_RD_SLAVE_SLVERR_EN, INCR ARADDR=(MEM_DEPTH-1)*8 ARLEN=1 ARSIZE=3 -> beat 1 RRESP=00, beat 2 RRESP=10 RDATA=0; without macro beat 2 returns word 0, RRESP=00.
